// File: rtl/jtag_ir_loader.sv
// jtag_ir_loader
//   Host-side JTAG initiator. Walks a target TAP from Run-Test/Idle through
//   an IR scan and back to Run-Test/Idle. The instruction is shifted in LSB
//   first, and the bits the target shifts out are collected in ir_captured.
//   It can also drive a five-cycle TMS=1 Test-Logic-Reset sequence.
//
// Ports
//   TCLK        in   single clock; the target samples TMS/TDI and this block
//                    samples TDO on the same rising edge
//   TRESETN     in   synchronous active-low reset
//   start       in   request an IR load of ir_in (accepted only in IDLE)
//   reset_tap   in   request a TAP reset (accepted only in IDLE, wins over start)
//   ir_in       in   instruction, latched when start is accepted
//   TDO         in   serial data from the target IR
//   TMS         out  test mode select to the target
//   TDI         out  serial data to the target IR
//   busy        out  high in every state except IDLE
//   done        out  one-cycle pulse in the first IDLE cycle after a load/reset
//   ir_captured out  bits shifted out of the target during the last IR load
//   dbg_state   out  current FSM state encoding, for observation only
//
// Handshake: start/reset_tap are level requests sampled on a rising TCLK
// edge. They are only taken when the FSM is in IDLE and done is low;
// requests that arrive while busy are dropped, not queued.

module jtag_ir_loader #(
  parameter int IR_WIDTH = 8
) (
  input  logic                TCLK,
  input  logic                TRESETN,
  input  logic                start,
  input  logic                reset_tap,
  input  logic [IR_WIDTH-1:0] ir_in,
  input  logic                TDO,
  output logic                TMS,
  output logic                TDI,
  output logic                busy,
  output logic                done,
  output logic [IR_WIDTH-1:0] ir_captured,
  output logic [3:0]          dbg_state
);

  // The counter must hold both IR_WIDTH-1 and the TLR count of 4.
  localparam int CNT_W = ($clog2(IR_WIDTH) < 3) ? 3 : $clog2(IR_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(IR_WIDTH - 1);
  localparam logic [CNT_W-1:0] TLR_LAST = CNT_W'(4);

  // Each state names the TAP state the target occupies during that cycle.
  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    RTI_GO   = 4'd1,
    SEL_DR   = 4'd2,
    SEL_IR   = 4'd3,
    CAP_IR   = 4'd4,
    SHIFT_IR = 4'd5,
    EXIT1_IR = 4'd6,
    UPD_IR   = 4'd7,
    TLR      = 4'd8,
    TLR_EXIT = 4'd9
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IR_WIDTH-1:0] shadow_q, shadow_d;
  logic [IR_WIDTH-1:0] capture_q, capture_d;
  logic [IR_WIDTH-1:0] ir_captured_q, ir_captured_d;
  logic                done_q, done_d;

  always_ff @(posedge TCLK) begin
    if (!TRESETN) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      shadow_q      <= '0;
      capture_q     <= '0;
      ir_captured_q <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shadow_q      <= shadow_d;
      capture_q     <= capture_d;
      ir_captured_q <= ir_captured_d;
      done_q        <= done_d;
    end
  end

  // Next-state logic. The counter defaults to zero so it is cleared on every
  // state entry; only SHIFT_IR and TLR advance it while they stay put.
  always_comb begin
    state_d       = state_q;
    cnt_d         = '0;
    shadow_d      = shadow_q;
    capture_d     = capture_q;
    ir_captured_d = ir_captured_q;
    done_d        = 1'b0;
    case (state_q)
      IDLE: begin
        // The done cycle never accepts a request, so done and acceptance
        // can never coincide.
        if (!done_q) begin
          if (reset_tap) begin
            state_d = TLR;
          end else if (start) begin
            state_d  = RTI_GO;
            shadow_d = ir_in;
          end
        end
      end
      RTI_GO:  state_d = SEL_DR;
      SEL_DR:  state_d = SEL_IR;
      SEL_IR:  state_d = CAP_IR;
      CAP_IR:  state_d = SHIFT_IR;
      SHIFT_IR: begin
        capture_d = {TDO, capture_q[IR_WIDTH-1:1]};
        if (cnt_q == LAST_BIT) begin
          state_d       = EXIT1_IR;
          // Publish including the bit sampled on this final edge.
          ir_captured_d = capture_d;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      EXIT1_IR: state_d = UPD_IR;
      UPD_IR: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      TLR: begin
        if (cnt_q == TLR_LAST) begin
          state_d = TLR_EXIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TLR_EXIT: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs: decoded from registered state only.
  always_comb begin
    TMS = 1'b0;
    TDI = 1'b0;
    case (state_q)
      RTI_GO:   TMS = 1'b1;
      SEL_DR:   TMS = 1'b1;
      SHIFT_IR: begin
        TMS = (cnt_q == LAST_BIT);
        TDI = shadow_q[cnt_q];
      end
      EXIT1_IR: TMS = 1'b1;
      TLR:      TMS = 1'b1;
      default:  TMS = 1'b0;
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign ir_captured = ir_captured_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_jtag_ir_loader.sv
// Testbench for jtag_ir_loader: drives loads and TAP resets against a
// behavioural IEEE 1149.1 TAP + 8-bit IR target model and scores the
// TMS/TDI streams, done timing, ir_captured and the target's IR output.

module tb_jtag_ir_loader;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic TCLK = 1'b0;
  logic TRESETN;
  always #5 TCLK = ~TCLK;

  logic         start, reset_tap;
  logic [W-1:0] ir_in;
  logic         TDO, TMS, TDI, busy, done;
  logic [W-1:0] ir_captured;
  logic [3:0]   dbg_state;

  jtag_ir_loader #(.IR_WIDTH(W)) dut (
    .TCLK        (TCLK),
    .TRESETN     (TRESETN),
    .start       (start),
    .reset_tap   (reset_tap),
    .ir_in       (ir_in),
    .TDO         (TDO),
    .TMS         (TMS),
    .TDI         (TDI),
    .busy        (busy),
    .done        (done),
    .ir_captured (ir_captured),
    .dbg_state   (dbg_state)
  );

  // ---------------- target TAP model ----------------
  typedef enum logic [3:0] {
    T_TLR, T_RTI, T_SDR, T_CDR, T_SHDR, T_E1DR, T_PDR, T_E2DR, T_UDR,
    T_SIR, T_CIR, T_SHIR, T_E1IR, T_PIR, T_E2IR, T_UIR
  } tap_t;

  function automatic tap_t tap_next(input tap_t s, input logic tms);
    case (s)
      T_TLR:  return tms ? T_TLR  : T_RTI;
      T_RTI:  return tms ? T_SDR  : T_RTI;
      T_SDR:  return tms ? T_SIR  : T_CDR;
      T_CDR:  return tms ? T_E1DR : T_SHDR;
      T_SHDR: return tms ? T_E1DR : T_SHDR;
      T_E1DR: return tms ? T_UDR  : T_PDR;
      T_PDR:  return tms ? T_E2DR : T_PDR;
      T_E2DR: return tms ? T_UDR  : T_SHDR;
      T_UDR:  return tms ? T_SDR  : T_RTI;
      T_SIR:  return tms ? T_TLR  : T_CIR;
      T_CIR:  return tms ? T_E1IR : T_SHIR;
      T_SHIR: return tms ? T_E1IR : T_SHIR;
      T_E1IR: return tms ? T_UIR  : T_PIR;
      T_PIR:  return tms ? T_E2IR : T_PIR;
      T_E2IR: return tms ? T_UIR  : T_SHIR;
      default: return tms ? T_SDR : T_RTI;
    endcase
  endfunction

  tap_t         tap_st = T_TLR;
  logic [W-1:0] tap_sr = '0;
  logic [W-1:0] tap_po = '0;
  bit           tap_en = 1'b0;

  // Capture-IR loads the current instruction; Test-Logic-Reset clears it.
  always @(posedge TCLK) begin
    if (tap_en) begin
      case (tap_st)
        T_TLR:  tap_po <= '0;
        T_CIR:  tap_sr <= tap_po;
        T_SHIR: tap_sr <= {TDI, tap_sr[W-1:1]};
        T_UIR:  tap_po <= tap_sr;
        default: ;
      endcase
      tap_st <= tap_next(tap_st, TMS);
    end
  end

  assign TDO = (tap_st == T_SHIR) ? tap_sr[0] : 1'b0;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];   // expected ir_captured at each done
  logic [W-1:0] po_q[$];    // expected target instruction after a load
  logic [W-1:0] tgt_exp;    // instruction the target should currently hold
  int n_checks = 0;
  int n_err    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge TCLK);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_load(input logic [W-1:0] val, input bit glitch);
    logic exp_tms, exp_tdi;
    logic [W-1:0] cap_e, po_e;
    exp_q.push_back(tgt_exp);
    po_q.push_back(val);
    ir_in = val;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < W + 6; k++) begin
      // TMS: 1,1,0,0, then 0 on shift bits except the last, then 1,0.
      if (k < 2)            exp_tms = 1'b1;
      else if (k < 4)       exp_tms = 1'b0;
      else if (k < W + 4)   exp_tms = (k == W + 3);
      else                  exp_tms = (k == W + 4);
      exp_tdi = (k >= 4 && k < W + 4) ? val[k-4] : 1'b0;
      check_eq($sformatf("load%0h_tms%0d", val, k), TMS, exp_tms);
      check_eq($sformatf("load%0h_tdi%0d", val, k), TDI, exp_tdi);
      if (k == 0 || k == W + 5) begin
        check_eq($sformatf("load%0h_busy%0d", val, k), busy, 1'b1);
        check_eq($sformatf("load%0h_done%0d", val, k), done, 1'b0);
      end
      if (glitch) begin
        start = (k == 3 || k == 9);
        if (k == 8) ir_in = ~val;
      end
      tick();
    end
    start = 1'b0;
    check_eq("load_done", done, 1'b1);
    check_eq("load_busy_fall", busy, 1'b0);
    cap_e = exp_q.pop_front();
    po_e  = po_q.pop_front();
    check_eq($sformatf("load%0h_ir_captured", val), ir_captured, cap_e);
    check_eq($sformatf("load%0h_target_po", val), tap_po, po_e);
    tgt_exp = val;
    tick();
    check_eq("load_done_one_cycle", done, 1'b0);
    check_eq("load_no_extra_txn", busy, 1'b0);
  endtask

  task automatic run_tlr(input bit with_start);
    logic [W-1:0] cap_e;
    // ir_captured must survive a TAP reset.
    exp_q.push_back(ir_captured);
    reset_tap = 1'b1;
    start     = with_start;
    ir_in     = 8'hFF;
    tick();
    reset_tap = 1'b0;
    start     = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check_eq($sformatf("tlr_tms%0d", k), TMS, (k < 5) ? 1'b1 : 1'b0);
      check_eq($sformatf("tlr_busy%0d", k), busy, 1'b1);
      check_eq($sformatf("tlr_done%0d", k), done, 1'b0);
      tick();
    end
    check_eq("tlr_done", done, 1'b1);
    check_eq("tlr_busy_fall", busy, 1'b0);
    cap_e = exp_q.pop_front();
    check_eq("tlr_ir_captured", ir_captured, cap_e);
    check_eq("tlr_target_rti", tap_st, T_RTI);
    tgt_exp = '0;
    tick();
    check_eq("tlr_no_scan_after", busy, 1'b0);
    check_eq("tlr_target_stays_rti", tap_st, T_RTI);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    TRESETN   = 1'b0;
    start     = 1'b0;
    reset_tap = 1'b0;
    ir_in     = '0;
    tgt_exp   = '0;
    tick();
    tick();
    check_eq("rst_tms", TMS, 1'b0);
    check_eq("rst_tdi", TDI, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_ir_captured", ir_captured, '0);
    check_eq("rst_state", dbg_state, 4'd0);
    TRESETN = 1'b1;
    tap_en  = 1'b1;
    tick();

    run_tlr(1'b0);

    // Abort a load with reset during shift bit 4.
    ir_in = 8'h77;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    check_eq("abort_in_shift_bit4", TDI, 1'b1);
    TRESETN = 1'b0;
    tick();
    TRESETN = 1'b1;
    check_eq("abort_tms", TMS, 1'b0);
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_done", done, 1'b0);
    check_eq("abort_state", dbg_state, 4'd0);
    tick();
    check_eq("abort_no_done", done, 1'b0);
    check_eq("abort_still_idle", busy, 1'b0);

    run_tlr(1'b0);
    run_load(8'h5A, 1'b0);
    run_tlr(1'b0);
    run_load(8'hA5, 1'b0);
    run_load(8'h3C, 1'b1);
    run_tlr(1'b1);
    run_load(W'($urandom_range(0, 255)), 1'b0);
    run_load(W'($urandom_range(0, 255)), 1'b1);

    check_eq("scoreboard_empty", exp_q.size() + po_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
